// File: rtl/ext_bus_refill_8051.sv
// 8051 external bus engine behind the cache controller.
// One byte read, code fetch or write per transaction.
module ext_bus_refill_8051 #(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_wr,
    input  logic        req_code,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        ale,
    output logic        psen_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  p2_addr,
    output logic [7:0]  p0_out,
    output logic        p0_oe,
    input  logic [7:0]  p0_in
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        STROBE,
        RECOVER,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] a_wdata;
    logic       a_wr;
    logic       a_code;
    logic [3:0] cnt;

    // Ready is decoded from the state register only.
    assign req_ready = (state == IDLE);

    // Bus cycle sequencer; every bus pin is a register updated with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_wdata    <= '0;
            a_wr       <= 1'b0;
            a_code     <= 1'b0;
            cnt        <= '0;
            ale        <= 1'b0;
            psen_n     <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            p2_addr    <= '0;
            p0_out     <= '0;
            p0_oe      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_wdata <= req_wdata;
                        a_wr    <= req_wr;
                        a_code  <= req_code & ~req_wr;
                        ale     <= 1'b1;
                        p0_oe   <= 1'b1;
                        p0_out  <= req_addr[7:0];
                        p2_addr <= req_addr[15:8];
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    ale   <= 1'b0;
                    state <= LATCH;
                end
                LATCH: begin
                    cnt   <= 4'(WAIT_STATES);
                    state <= STROBE;
                    if (a_wr) begin
                        wr_n   <= 1'b0;
                        p0_out <= a_wdata;
                    end else begin
                        p0_oe <= 1'b0;
                        if (a_code) begin
                            psen_n <= 1'b0;
                        end else begin
                            rd_n <= 1'b0;
                        end
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        psen_n <= 1'b1;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        p0_oe  <= a_wr;
                        if (!a_wr) begin
                            resp_data <= p0_in;
                        end
                        state <= RECOVER;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    p0_oe      <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_refill_8051.sv
// Bench for ext_bus_refill_8051: scoreboarded responses,
// bus phase checks, abort by reset and a zero-wait build.
module tb_ext_bus_refill_8051;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic [15:0] req_addr = '0;
    logic        req_wr = 1'b0;
    logic        req_code = 1'b0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  p0_in = '0;

    logic        req_ready, resp_valid, ale, psen_n, rd_n, wr_n, p0_oe;
    logic [7:0]  resp_data, p2_addr, p0_out;
    logic        req_ready0, resp_valid0, ale0, psen_n0, rd_n0, wr_n0, p0_oe0;
    logic [7:0]  resp_data0, p2_addr0, p0_out0;

    always #5 clk = ~clk;

    ext_bus_refill_8051 #(.WAIT_STATES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_code(req_code),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
        .p2_addr(p2_addr), .p0_out(p0_out), .p0_oe(p0_oe),
        .p0_in(p0_in)
    );

    ext_bus_refill_8051 #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_wr(req_wr), .req_code(req_code),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_data(resp_data0),
        .ale(ale0), .psen_n(psen_n0), .rd_n(rd_n0), .wr_n(wr_n0),
        .p2_addr(p2_addr0), .p0_out(p0_out0), .p0_oe(p0_oe0),
        .p0_in(p0_in)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         acc_q[$];
    logic [7:0] model_rd = '0;
    int         nlow;

    // Scoreboard: push on accept, pop on resp_valid; strobe exclusivity.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_rd = '0;
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc + 1);
                if (!req_wr) model_rd = p0_in;
                sb.push_back('{cyc + 1 + 4 + W, model_rd});
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_spurious", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_data", resp_data, e.data);
                end
            end
            nlow = int'(!psen_n) + int'(!rd_n) + int'(!wr_n);
            if (nlow != 0) check("strobe_excl", {ale, 4'(nlow)}, 5'd1);
        end
    end

    task automatic bus_txn(input logic [15:0] a, input logic wr,
                           input logic code, input logic [7:0] wd,
                           input logic [7:0] pin);
        int acc = -1;
        logic [2:0] sexp;
        sexp = wr ? 3'b110 : (code ? 3'b011 : 3'b101);
        @(negedge clk);
        req_addr = a; req_wr = wr; req_code = code;
        req_wdata = wd; p0_in = pin; req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = ~a; req_wdata = ~wd; req_code = ~code;
        @(negedge clk);
        check("addr_ale", ale, 1'b1);
        check("addr_p2", p2_addr, a[15:8]);
        check("addr_p0", p0_out, a[7:0]);
        check("addr_oe", p0_oe, 1'b1);
        @(negedge clk);
        check("latch_ale", ale, 1'b0);
        check("latch_p0", {p0_oe, p0_out}, {1'b1, a[7:0]});
        check("latch_strb", {psen_n, rd_n, wr_n}, 3'b111);
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            check("strobe", {psen_n, rd_n, wr_n}, sexp);
            check("strobe_oe", p0_oe, wr);
            if (wr) check("strobe_wd", p0_out, wd);
        end
        @(negedge clk);
        check("recover_strb", {psen_n, rd_n, wr_n}, 3'b111);
        check("recover_oe", p0_oe, wr);
        @(negedge clk);
        check("done_oe", p0_oe, 1'b0);
        check("done_ready", req_ready, 1'b0);
        @(negedge clk);
        check("idle_ready", req_ready, 1'b1);
        check("idle_p2", p2_addr, a[15:8]);
    endtask

    initial begin
        int acc;
        int got;
        int low;
        repeat (3) @(negedge clk);
        check("rst_strb", {ale, psen_n, rd_n, wr_n, p0_oe}, 5'b01110);
        check("rst_p0_p2", {p0_out, p2_addr}, 16'h0000);
        check("rst_resp", {resp_valid, resp_data}, 9'h000);
        check("rst_ready", req_ready, 1'b1);
        #1 rst = 1'b0;

        bus_txn(16'h12C4, 1'b0, 1'b0, 8'h00, 8'h5A);
        bus_txn(16'h0040, 1'b0, 1'b1, 8'h00, 8'hA7);
        bus_txn(16'hFF00, 1'b1, 1'b0, 8'h3C, 8'h00);
        bus_txn(16'h0102, 1'b1, 1'b1, 8'hE1, 8'h55);
        check("wr_keeps_data", resp_data, 8'hA7);

        // Two reads with req_valid held high throughout.
        @(negedge clk);
        acc_q.delete();
        req_addr = 16'h3456; req_wr = 1'b0; req_code = 1'b0;
        p0_in = 8'h77; req_valid = 1'b1;
        for (int i = 0; i < 40 && acc_q.size() < 2; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (acc_q.size() < 2) check("b2b_timeout", 32'd0, 32'd1);
        else check("b2b_period", acc_q[1] - acc_q[0], 32'd6 + W);
        repeat (10) @(negedge clk);

        // Reset during the strobe of a read.
        req_addr = 16'h2222; p0_in = 8'h11; req_valid = 1'b1;
        acc = cyc + 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (cyc < acc + 3) @(negedge clk);
        check("abort_pre", rd_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_bus", {rd_n, p0_oe, ale}, 3'b100);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_ready", req_ready, 1'b1);
        check("abort_rdata", resp_data, 8'h00);

        bus_txn(16'hABCD, 1'b0, 1'b0, 8'h00, 8'h42);

        // Zero wait-state build.
        @(negedge clk);
        req_addr = 16'h0001; req_wr = 1'b0; req_code = 1'b0;
        p0_in = 8'h99; req_valid0 = 1'b1;
        check("ws0_ready", req_ready0, 1'b1);
        acc = cyc + 1;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        low = 0;
        got = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!rd_n0) low++;
            if (resp_valid0) begin
                got = cyc;
                check("ws0_data", resp_data0, 8'h99);
            end
        end
        check("ws0_strobe_len", low, 32'd1);
        check("ws0_resp_cycle", got, acc + 4);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
